s32x_sdr_responder: RTL



---
 rtl/s32x_sdr_responder.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/s32x_sdr_responder.sv
// SH-2 SDRAM-port responder: WAIT handshake toward the initiator, one req/ack backend transaction
// per access. Define S32X_SDR_RDCACHE_EN to add a one-entry write-through read cache.
module s32x_sdr_responder #(
  parameter int unsigned MIN_WAIT = 4,
  parameter int unsigned ADDR_W   = 17
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [ADDR_W-1:0] SDR_A,
  input  logic [15:0]       SDR_DO,
  input  logic              SDR_CS,
  input  logic [1:0]        SDR_WE,
  input  logic              SDR_RD,
  output logic [15:0]       SDR_DI,
  output logic              SDR_WAIT,
  output logic [ADDR_W-1:0] MEM_A,
  output logic [15:0]       MEM_DO,
  output logic [1:0]        MEM_BE,
  output logic              MEM_WR,
  output logic              MEM_REQ,
  input  logic [15:0]       MEM_DI,
  input  logic              MEM_ACK
);

  localparam int unsigned CntW = (MIN_WAIT > 1) ? $clog2(MIN_WAIT) : 1;
  localparam logic [CntW-1:0] CntLoad = CntW'(MIN_WAIT - 1);

  typedef enum logic [1:0] {StIdle, StBusy, StHold} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              done_q, done_d;
  logic              abort_q, abort_d;
  logic              wait_q, wait_d;
  logic              req_q, req_d;
  logic              wr_q, wr_d;
  logic [1:0]        be_q, be_d;
  logic [ADDR_W-1:0] a_q, a_d;
  logic [15:0]       do_q, do_d;
  logic [15:0]       di_q, di_d;

  logic stb, is_wr;
  assign is_wr = |SDR_WE;
  assign stb   = SDR_CS & (SDR_RD | is_wr);

`ifdef S32X_SDR_RDCACHE_EN
  logic              valid_q, valid_d;
  logic [ADDR_W-1:0] tag_q, tag_d;
  logic [15:0]       cdata_q, cdata_d;
  logic              tag_match;
  assign tag_match = valid_q && (tag_q == SDR_A);
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = done_q;
    abort_d = abort_q;
    wait_d  = wait_q;
    req_d   = req_q;
    wr_d    = wr_q;
    be_d    = be_q;
    a_d     = a_q;
    do_d    = do_q;
    di_d    = di_q;
`ifdef S32X_SDR_RDCACHE_EN
    valid_d = valid_q;
    tag_d   = tag_q;
    cdata_d = cdata_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (stb) begin
          a_d     = SDR_A;
          do_d    = SDR_DO;
          wr_d    = is_wr;
          be_d    = is_wr ? SDR_WE : 2'b11;
          req_d   = 1'b1;
          wait_d  = 1'b1;
          cnt_d   = CntLoad;
          done_d  = 1'b0;
          abort_d = 1'b0;
          state_d = StBusy;
`ifdef S32X_SDR_RDCACHE_EN
          if (tag_match && !is_wr) begin
            req_d  = 1'b0;
            done_d = 1'b1;
            di_d   = cdata_q;
          end
          // Write-through: keep the cached copy coherent, backend still gets the write.
          if (tag_match && is_wr) begin
            if (SDR_WE[1]) cdata_d[15:8] = SDR_DO[15:8];
            if (SDR_WE[0]) cdata_d[7:0]  = SDR_DO[7:0];
          end
`endif
        end
      end
      StBusy: begin
        if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
        if (!stb) abort_d = 1'b1;
        if (req_q && MEM_ACK) begin
          req_d  = 1'b0;
          done_d = 1'b1;
          if (!wr_q) begin
            di_d = MEM_DI;
`ifdef S32X_SDR_RDCACHE_EN
            valid_d = 1'b1;
            tag_d   = a_q;
            cdata_d = MEM_DI;
`endif
          end
        end
        if (done_q && (cnt_q == '0)) begin
          wait_d  = 1'b0;
          state_d = (abort_q || !stb) ? StIdle : StHold;
        end
      end
      StHold: begin
        if (!stb) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      abort_q <= 1'b0;
      wait_q  <= 1'b0;
      req_q   <= 1'b0;
      wr_q    <= 1'b0;
      be_q    <= 2'b00;
      a_q     <= '0;
      do_q    <= '0;
      di_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      abort_q <= abort_d;
      wait_q  <= wait_d;
      req_q   <= req_d;
      wr_q    <= wr_d;
      be_q    <= be_d;
      a_q     <= a_d;
      do_q    <= do_d;
      di_q    <= di_d;
    end
  end

`ifdef S32X_SDR_RDCACHE_EN
  always_ff @(posedge CLK) begin
    if (RST) begin
      valid_q <= 1'b0;
      tag_q   <= '0;
      cdata_q <= '0;
    end else begin
      valid_q <= valid_d;
      tag_q   <= tag_d;
      cdata_q <= cdata_d;
    end
  end
`endif

  assign SDR_DI   = di_q;
  assign SDR_WAIT = wait_q;
  assign MEM_A    = a_q;
  assign MEM_DO   = do_q;
  assign MEM_BE   = be_q;
  assign MEM_WR   = wr_q;
  assign MEM_REQ  = req_q;

endmodule
